// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state encoding, next-state function,
// scan command opcodes and the sequencer state type.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EX1_DR,
    TAP_PAUSE_DR,
    TAP_EX2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EX1_IR,
    TAP_PAUSE_IR,
    TAP_EX2_IR,
    TAP_UPD_IR
  } tap_state_t;

  typedef enum logic [3:0] {
    WALK,
    IDLE,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    TLR,
    RESP
  } seq_state_t;

  localparam logic [1:0] OP_NOP       = 2'b00;
  localparam logic [1:0] OP_SHIFT_IR  = 2'b01;
  localparam logic [1:0] OP_SHIFT_DR  = 2'b10;
  localparam logic [1:0] OP_TAP_RESET = 2'b11;

  function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
    tap_state_t nxt;
    nxt = TAP_TLR;
    case (state)
      TAP_TLR:      nxt = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   nxt = tms ? TAP_EX1_DR   : TAP_SHIFT_DR;
      TAP_SHIFT_DR: nxt = tms ? TAP_EX1_DR   : TAP_SHIFT_DR;
      TAP_EX1_DR:   nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: nxt = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   nxt = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   nxt = tms ? TAP_EX1_IR   : TAP_SHIFT_IR;
      TAP_SHIFT_IR: nxt = tms ? TAP_EX1_IR   : TAP_SHIFT_IR;
      TAP_EX1_IR:   nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: nxt = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tap_state_mirror.sv
// Registered copy of the target TAP controller state, advanced by the TMS value
// presented before each TCK rising edge.
module tap_state_mirror
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRSTn,
  input  logic       TMS,
  output tap_state_t state
);

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      state <= TAP_TLR;
    end else begin
      state <= tap_next(state, TMS);
    end
  end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// Host-side JTAG master: converts IR/DR shift and TAP reset commands into TMS/TDI
// sequences, collects TDO, and always parks the target TAP in Run-Test/Idle.
module jtag_scan_sequencer
  import jtag_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               TCK,
  input  logic               TRSTn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  seq_state_t         state;
  tap_state_t         mirror;
  logic               is_ir;
  logic               err_q;
  logic [IDX_W-1:0]   cnt;
  logic [IDX_W-1:0]   last_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] cap_q;
  logic               in_shift;
  logic               accept;
  logic               len_ok;
  logic               is_shift_op;

  tap_state_mirror u_mirror (
    .TCK   (TCK),
    .TRSTn (TRSTn),
    .TMS   (TMS),
    .state (mirror)
  );

  assign in_shift    = (mirror == TAP_SHIFT_DR) || (mirror == TAP_SHIFT_IR);
  assign cmd_ready   = (state == IDLE) && (mirror == TAP_RTI) && !rsp_valid;
  assign accept      = cmd_valid && cmd_ready;
  assign len_ok      = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN));
  assign is_shift_op = (cmd_op == OP_SHIFT_IR) || (cmd_op == OP_SHIFT_DR);

  // TMS/TDI are registered one edge ahead: the value set at an edge is what the
  // TAP (and the mirror) consumes on the following edge.
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      state     <= WALK;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      is_ir     <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
      last_q    <= '0;
      data_q    <= '0;
      cap_q     <= '0;
    end else begin
      case (state)
        WALK: begin
          if (TMS) begin
            TMS <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        IDLE: begin
          TMS <= 1'b0;
          TDI <= 1'b0;
          if (accept) begin
            cnt    <= '0;
            cap_q  <= '0;
            data_q <= cmd_data;
            last_q <= IDX_W'(cmd_len - 1'b1);
            is_ir  <= (cmd_op == OP_SHIFT_IR);
            err_q  <= is_shift_op && !len_ok;
            if (is_shift_op && len_ok) begin
              TMS   <= 1'b1;
              state <= SEL_DR;
            end else if (cmd_op == OP_TAP_RESET) begin
              TMS   <= 1'b1;
              state <= TLR;
            end else begin
              state <= UPDATE;
            end
          end
        end

        SEL_DR: begin
          TMS   <= is_ir;
          state <= is_ir ? SEL_IR : CAPTURE;
        end

        SEL_IR: begin
          TMS   <= 1'b0;
          state <= CAPTURE;
        end

        CAPTURE: begin
          TMS   <= 1'b0;
          state <= SHIFT;
        end

        // First edge here only enters Shift; every later edge samples one bit.
        SHIFT: begin
          if (!in_shift) begin
            TDI <= data_q[0];
            TMS <= (last_q == '0);
          end else begin
            cap_q[cnt] <= TDO;
            if (cnt == last_q) begin
              TDI   <= 1'b0;
              TMS   <= 1'b1;
              state <= EXIT1;
            end else begin
              cnt <= cnt + 1'b1;
              TDI <= data_q[cnt + 1'b1];
              TMS <= (cnt + 1'b1 == last_q);
            end
          end
        end

        EXIT1: begin
          TMS   <= 1'b0;
          state <= UPDATE;
        end

        UPDATE: begin
          TMS       <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= cap_q;
          rsp_err   <= err_q;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        // Five TMS=1 edges reach Test-Logic-Reset from anywhere; the sixth (TMS=0) lands in RTI.
        TLR: begin
          if (cnt == IDX_W'(4)) begin
            TMS   <= 1'b0;
            state <= UPDATE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= WALK;
          TMS   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: behavioural target TAP (2-bit IR, bypass, 51-bit
// loopback BSR) plus a table of commands with hand-computed TMS/TDI/TDO results.
module tb_jtag_scan_sequencer;
  import jtag_pkg::*;

  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned LEN_W   = 7;
  localparam int unsigned BSR_LEN = 51;
  localparam logic [MAX_LEN-1:0] BSR_PAT = 64'h0005_A5A5_A5A5_A5A5;

  logic               TCK = 1'b0;
  logic               TRSTn = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = OP_NOP;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               TMS;
  logic               TDI;
  logic               TDO;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 TCK = ~TCK;

  jtag_scan_sequencer #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .TCK       (TCK),
    .TRSTn     (TRSTn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
  );

  // Target TAP model
  tap_state_t         mon_state;
  logic [1:0]         ir = 2'b11;
  logic [1:0]         ir_sr = 2'b00;
  logic               byp = 1'b0;
  logic [BSR_LEN-1:0] bsr = '0;

  tap_state_mirror u_mon (
    .TCK   (TCK),
    .TRSTn (TRSTn),
    .TMS   (TMS),
    .state (mon_state)
  );

  always @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      ir <= 2'b11;
    end else begin
      case (mon_state)
        TAP_TLR:      ir <= 2'b11;
        TAP_CAP_IR:   ir_sr <= 2'b01;
        TAP_SHIFT_IR: ir_sr <= {TDI, ir_sr[1]};
        TAP_UPD_IR:   ir <= ir_sr;
        TAP_CAP_DR:   byp <= 1'b0;
        TAP_SHIFT_DR: begin
          if (ir == 2'b00) bsr <= {TDI, bsr[BSR_LEN-1:1]};
          else             byp <= TDI;
        end
        default: ;
      endcase
    end
  end

  assign TDO = (mon_state == TAP_SHIFT_IR) ? ir_sr[0] :
               (mon_state == TAP_SHIFT_DR) ? ((ir == 2'b00) ? bsr[0] : byp) : 1'b0;

  typedef struct {
    logic [1:0]         op;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] data;
    logic [MAX_LEN-1:0] exp_data;
    logic               exp_err;
    int unsigned        exp_lat;
    logic [1:0]         exp_ir;
    int unsigned        hold;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mkv(input logic [1:0] op, input int unsigned len,
                               input logic [MAX_LEN-1:0] data, input logic [MAX_LEN-1:0] exp_data,
                               input logic exp_err, input int unsigned exp_lat,
                               input logic [1:0] exp_ir, input int unsigned hold);
    vec_t v;
    v.op = op;  v.len = LEN_W'(len);  v.data = data;  v.exp_data = exp_data;
    v.exp_err = exp_err;  v.exp_lat = exp_lat;  v.exp_ir = exp_ir;  v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_tms(input vec_t v);
    logic [127:0] s;
    int p;
    s = '0;
    p = 0;
    if (v.exp_err || v.op == OP_NOP) return s;
    if (v.op == OP_TAP_RESET) begin
      s[4:0] = 5'h1f;
      return s;
    end
    s[p] = 1'b1; p++;
    if (v.op == OP_SHIFT_IR) begin s[p] = 1'b1; p++; end
    p = p + 2 + int'(v.len) - 1;
    s[p] = 1'b1;
    s[p+1] = 1'b1;
    return s;
  endfunction

  task automatic run_cmd(input vec_t v, input int idx);
    logic [127:0]       tms_seq;
    logic [MAX_LEN-1:0] tdi_seq;
    logic [MAX_LEN-1:0] exp_tdi;
    logic [MAX_LEN-1:0] held;
    int unsigned        n_tdi, exp_n, lat, w;
    logic               tdi_stray, stable;
    string              tag;
    tag = $sformatf("v%0d", idx);
    tms_seq = '0;  tdi_seq = '0;  n_tdi = 0;  lat = 0;  tdi_stray = 1'b0;  stable = 1'b1;
    @(negedge TCK);
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge TCK);
      w++;
    end
    chk({tag, "_ready_before"}, 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1;  cmd_op = v.op;  cmd_len = v.len;  cmd_data = v.data;
    @(posedge TCK); #1;
    cmd_valid = 1'b0;  cmd_op = OP_TAP_RESET;  cmd_len = LEN_W'(5);  cmd_data = ~v.data;
    for (int e = 1; e <= 200 && lat == 0; e++) begin
      if (e <= 128) tms_seq[e-1] = TMS;
      if (mon_state == TAP_SHIFT_DR || mon_state == TAP_SHIFT_IR) begin
        if (n_tdi < MAX_LEN) tdi_seq[n_tdi] = TDI;
        n_tdi++;
      end else if (TDI) begin
        tdi_stray = 1'b1;
      end
      @(posedge TCK); #1;
      if (rsp_valid) lat = e;
    end
    exp_n = 0;
    exp_tdi = '0;
    if (!v.exp_err && (v.op == OP_SHIFT_IR || v.op == OP_SHIFT_DR)) begin
      exp_n = v.len;
      for (int i = 0; i < int'(v.len); i++) exp_tdi[i] = v.data[i];
    end
    chk({tag, "_latency"}, 128'(lat), 128'(v.exp_lat));
    chk({tag, "_tms_seq"}, tms_seq, exp_tms(v));
    chk({tag, "_tdi_shift"}, {16'(n_tdi), tdi_seq}, {16'(exp_n), exp_tdi});
    chk({tag, "_tdi_idle"}, 128'(tdi_stray), 128'(0));
    chk({tag, "_rsp_data"}, 128'(rsp_data), 128'(v.exp_data));
    chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(v.exp_err));
    chk({tag, "_tap_rti"}, 128'(mon_state), 128'(TAP_RTI));
    chk({tag, "_ir"}, 128'(ir), 128'(v.exp_ir));
    held = rsp_data;
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge TCK);
      if (!rsp_valid || rsp_data !== held || cmd_ready || TMS || TDI) stable = 1'b0;
    end
    if (v.hold != 0) chk({tag, "_hold_stable"}, 128'(stable), 128'(1));
    @(negedge TCK);
    rsp_ready = 1'b1;
    @(posedge TCK); #1;
    rsp_ready = 1'b0;
    chk({tag, "_consumed"}, {127'(0), rsp_valid}, 128'(0));
    chk({tag, "_ready_after"}, 128'(cmd_ready), 128'(1));
  endtask

  task automatic chk_walk(input string tag);
    @(posedge TCK); #1;
    chk({tag, "_e1_tms"}, 128'(TMS), 128'(0));
    chk({tag, "_e1_tap"}, 128'(mon_state), 128'(TAP_TLR));
    chk({tag, "_e1_ready"}, 128'(cmd_ready), 128'(0));
    chk({tag, "_e1_rsp"}, 128'(rsp_valid), 128'(0));
    @(posedge TCK); #1;
    chk({tag, "_e2_tap"}, 128'(mon_state), 128'(TAP_RTI));
    chk({tag, "_e2_ready"}, 128'(cmd_ready), 128'(1));
    chk({tag, "_e2_tms"}, 128'(TMS), 128'(0));
    chk({tag, "_e2_rsp"}, 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mkv(OP_SHIFT_IR,  2,  64'h3,   64'h1,   1'b0, 8,  2'b11, 0);
    vecs[1]  = mkv(OP_SHIFT_IR,  2,  64'h0,   64'h1,   1'b0, 8,  2'b00, 0);
    vecs[2]  = mkv(OP_SHIFT_DR,  51, BSR_PAT, 64'h0,   1'b0, 56, 2'b00, 0);
    vecs[3]  = mkv(OP_SHIFT_DR,  51, BSR_PAT, BSR_PAT, 1'b0, 56, 2'b00, 0);
    vecs[4]  = mkv(OP_SHIFT_IR,  2,  64'h3,   64'h1,   1'b0, 8,  2'b11, 0);
    vecs[5]  = mkv(OP_SHIFT_DR,  1,  64'h1,   64'h0,   1'b0, 6,  2'b11, 0);
    vecs[6]  = mkv(OP_NOP,       0,  '1,      64'h0,   1'b0, 1,  2'b11, 0);
    vecs[7]  = mkv(OP_SHIFT_DR,  0,  '1,      64'h0,   1'b1, 1,  2'b11, 10);
    vecs[8]  = mkv(OP_SHIFT_IR,  65, '1,      64'h0,   1'b1, 1,  2'b11, 10);
    vecs[9]  = mkv(OP_TAP_RESET, 0,  64'h0,   64'h0,   1'b0, 6,  2'b11, 0);
    vecs[10] = mkv(OP_SHIFT_DR,  3,  64'h5,   64'h2,   1'b0, 8,  2'b11, 0);
    vecs[11] = mkv(OP_SHIFT_DR,  64, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 69, 2'b11, 0);

    // Reset values and the two-edge walk to RTI
    #12;
    chk("rst_tms", 128'(TMS), 128'(1));
    chk("rst_outputs", {TDI, cmd_ready, rsp_valid, rsp_err, rsp_data}, '0);
    @(negedge TCK);
    TRSTn = 1'b1;
    chk_walk("walk");

    foreach (vecs[i]) run_cmd(vecs[i], i);

    // Response retire and new command offered on the same edge
    @(negedge TCK);
    cmd_valid = 1'b1;  cmd_op = OP_NOP;  cmd_len = '0;
    @(posedge TCK); #1;
    cmd_valid = 1'b0;
    @(posedge TCK); #1;
    chk("sim_nop_rsp", {rsp_valid, rsp_err}, 128'(2'b10));
    @(negedge TCK);
    rsp_ready = 1'b1;  cmd_valid = 1'b1;  cmd_op = OP_SHIFT_DR;  cmd_len = '0;
    @(posedge TCK); #1;
    rsp_ready = 1'b0;
    chk("sim_retire", {rsp_valid, cmd_ready}, 128'(2'b01));
    @(posedge TCK); #1;
    cmd_valid = 1'b0;
    chk("sim_accept", {rsp_valid, cmd_ready}, 128'(2'b00));
    @(posedge TCK); #1;
    chk("sim_err_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b11, 64'h0});
    @(negedge TCK);
    rsp_ready = 1'b1;
    @(posedge TCK); #1;
    rsp_ready = 1'b0;

    // Abort a 51-bit bypass DR shift while bit 20 is on TDI
    @(negedge TCK);
    chk("abort_ready", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1;  cmd_op = OP_SHIFT_DR;  cmd_len = LEN_W'(51);  cmd_data = BSR_PAT;
    @(posedge TCK); #1;
    cmd_valid = 1'b0;
    repeat (23) @(posedge TCK);
    #1;
    chk("abort_in_shift", {128'(mon_state), TDI}, {128'(TAP_SHIFT_DR), BSR_PAT[20]});
    #2;
    TRSTn = 1'b0;
    #1;
    chk("abort_outputs", {TMS, TDI, cmd_ready, rsp_valid, rsp_err, rsp_data}, {5'b10000, 64'h0});
    @(negedge TCK);
    @(negedge TCK);
    TRSTn = 1'b1;
    chk_walk("rewalk");
    run_cmd(vecs[9], 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
